// File: rtl/oflow_pe_seq_if.sv
// oflow_pe_seq_if: core-side and PE-side handshake bundle of the per-PE sequencer.
interface oflow_pe_seq_if #(parameter int SET_LEN = 8);
  logic               start_frame;
  logic [SET_LEN-1:0] num_of_sets;
  logic               first_frame;
  logic               done_fe;
  logic               done_registration;
  logic               start_fe;
  logic               start_registration;
  logic               done_pe;
  logic               frame_done;
  logic               ready_new_frame;
  logic               frame_num;
  logic [SET_LEN-1:0] set_idx;
  logic               busy;
  logic               timeout_err;
  modport master (
    output start_frame, num_of_sets, first_frame, done_fe, done_registration,
    input  start_fe, start_registration, done_pe, frame_done, ready_new_frame,
           frame_num, set_idx, busy, timeout_err
  );
  modport slave (
    input  start_frame, num_of_sets, first_frame, done_fe, done_registration,
    output start_fe, start_registration, done_pe, frame_done, ready_new_frame,
           frame_num, set_idx, busy, timeout_err
  );
endinterface

// File: rtl/oflow_pe_seq.sv
// oflow_pe_seq: drives one oflow_pe through a frame, set by set, with a handshake watchdog.
module oflow_pe_seq #(
  parameter int SET_LEN        = 8,
  parameter int TO_LEN         = 12,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input logic           clk,
  input logic           reset_N,
  oflow_pe_seq_if.slave io
);
  typedef enum logic [2:0] {IDLE, FE_START, FE_WAIT, REG_START, REG_WAIT, SET_END, FRAME_END} state_t;
  state_t             st, nxt;
  logic [SET_LEN-1:0] sets_q;
  logic               first_q;
  logic [TO_LEN-1:0]  cnt;
  logic               waiting, wd, last, to;
  assign waiting = st == FE_WAIT || st == REG_WAIT;
  assign wd      = TIMEOUT_CYCLES != 0 && cnt == TO_LEN'(TIMEOUT_CYCLES - 1);
  assign last    = io.set_idx == sets_q - 1'b1;
  // Outputs are registered from the next state, so each pulse lines up with its state.
  always_comb begin
    nxt = st;
    to  = 1'b0;
    case (st)
      IDLE:      if (io.start_frame) nxt = io.num_of_sets == '0 ? FRAME_END : FE_START;
      FE_START:  nxt = FE_WAIT;
      FE_WAIT:   if (io.done_fe) nxt = first_q ? SET_END : REG_START;
                 else if (wd) begin
                   nxt = IDLE;
                   to  = 1'b1;
                 end
      REG_START: nxt = REG_WAIT;
      REG_WAIT:  if (io.done_registration) nxt = SET_END;
                 else if (wd) begin
                   nxt = IDLE;
                   to  = 1'b1;
                 end
      SET_END:   nxt = last ? FRAME_END : FE_START;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      st                    <= IDLE;
      sets_q                <= '0;
      first_q               <= 1'b0;
      cnt                   <= '0;
      io.start_fe           <= 1'b0;
      io.start_registration <= 1'b0;
      io.done_pe            <= 1'b0;
      io.frame_done         <= 1'b0;
      io.ready_new_frame    <= 1'b1;
      io.busy               <= 1'b0;
      io.frame_num          <= 1'b0;
      io.set_idx            <= '0;
      io.timeout_err        <= 1'b0;
    end else begin
      st                    <= nxt;
      io.start_fe           <= nxt == FE_START;
      io.start_registration <= nxt == REG_START;
      io.done_pe            <= nxt == SET_END;
      io.frame_done         <= nxt == FRAME_END;
      io.ready_new_frame    <= nxt == IDLE;
      io.busy               <= nxt != IDLE;
      cnt                   <= !waiting ? '0 : cnt == '1 ? cnt : cnt + 1'b1;
      if (st == IDLE && io.start_frame) begin
        sets_q         <= io.num_of_sets;
        first_q        <= io.first_frame;
        io.set_idx     <= '0;
        io.timeout_err <= 1'b0;
      end
      if (to) io.timeout_err <= 1'b1;
      if (st == SET_END && !last) io.set_idx <= io.set_idx + 1'b1;
      if (st == FRAME_END) io.frame_num <= ~io.frame_num;
    end
  end
endmodule
